// File: rtl/mvu_pe_acc.sv
// Per-lane synapse-fold accumulator behind the MVU PE array, with a valid/ready output slice.
// Define MVU_ACC_SAT_EN for saturating adds and the out_sat flag; the default build wraps.
module mvu_pe_acc #(
    parameter  int PE = 2,
    parameter  int TO = 16,
    parameter  int TA = 24,
    parameter  int SF = 4,
    localparam int CW = (SF > 1) ? $clog2(SF) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_v,
    output logic              in_rdy,
    input  logic [PE*TO-1:0]  in_data,
    output logic              out_v,
    input  logic              out_rdy,
    output logic [PE*TA-1:0]  out_data,
`ifdef MVU_ACC_SAT_EN
    output logic              out_sat,
`endif
    output logic [CW-1:0]     sf_idx
);

    logic [CW-1:0]        sf_cnt;
    logic signed [TA-1:0] acc     [PE];
    logic signed [TA-1:0] ext     [PE];
    logic signed [TA-1:0] sum     [PE];
    logic signed [TA-1:0] fin_val [PE];
    logic                 accept;
    logic                 first_beat;
    logic                 last_beat;

    // A held, untaken result freezes the whole fold, so no beat can overrun it.
    assign in_rdy     = !(out_v && !out_rdy);
    assign accept     = in_v && in_rdy;
    assign first_beat = (sf_cnt == '0);
    assign last_beat  = (sf_cnt == CW'(SF - 1));
    assign sf_idx     = sf_cnt;

`ifdef MVU_ACC_SAT_EN
    logic [TA:0]   wide [PE];
    logic [PE-1:0] ovf;
    logic [PE-1:0] sat_sticky;

    always_comb begin
        for (int p = 0; p < PE; p++) begin
            ext[p]  = TA'($signed(in_data[p*TO +: TO]));
            wide[p] = {acc[p][TA-1], acc[p]} + {ext[p][TA-1], ext[p]};
            // Operand signs agree but the result sign differs: clamp toward the operand sign.
            ovf[p]  = wide[p][TA] ^ wide[p][TA-1];
            if (ovf[p])
                sum[p] = wide[p][TA] ? {1'b1, {(TA-1){1'b0}}} : {1'b0, {(TA-1){1'b1}}};
            else
                sum[p] = wide[p][TA-1:0];
            fin_val[p] = (SF == 1) ? ext[p] : sum[p];
        end
    end
`else
    always_comb begin
        for (int p = 0; p < PE; p++) begin
            ext[p]     = TA'($signed(in_data[p*TO +: TO]));
            sum[p]     = acc[p] + ext[p];
            fin_val[p] = (SF == 1) ? ext[p] : sum[p];
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sf_cnt   <= '0;
            out_v    <= 1'b0;
            out_data <= '0;
            // NOTE: the accumulator array is small flops, not RAM, so clearing it on reset is cheap and keeps state defined.
            for (int p = 0; p < PE; p++)
                acc[p] <= '0;
`ifdef MVU_ACC_SAT_EN
            sat_sticky <= '0;
            out_sat    <= 1'b0;
`endif
        end else begin
            if (out_v && out_rdy)
                out_v <= 1'b0;
            if (accept) begin
                if (last_beat) begin
                    for (int p = 0; p < PE; p++)
                        out_data[p*TA +: TA] <= fin_val[p];
                    out_v  <= 1'b1;
                    sf_cnt <= '0;
`ifdef MVU_ACC_SAT_EN
                    out_sat <= (SF == 1) ? 1'b0 : |(sat_sticky | ovf);
`endif
                end else begin
                    sf_cnt <= sf_cnt + CW'(1);
                    for (int p = 0; p < PE; p++)
                        acc[p] <= first_beat ? ext[p] : sum[p];
`ifdef MVU_ACC_SAT_EN
                    sat_sticky <= first_beat ? '0 : (sat_sticky | ovf);
                    if (first_beat)
                        out_sat <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Directed bench for mvu_pe_acc: SF=4 main instance, an SF=1 throughput instance and a TA=TO overflow instance.
module tb_mvu_pe_acc;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Main instance: PE=2, TO=16, TA=24, SF=4
    logic        in_v, in_rdy, out_v, out_rdy;
    logic [31:0] in_data;
    logic [47:0] out_data;
    logic [1:0]  sf_idx;
`ifdef MVU_ACC_SAT_EN
    logic        out_sat;
`endif

    mvu_pe_acc #(.PE(2), .TO(16), .TA(24), .SF(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy), .in_data(in_data),
        .out_v(out_v), .out_rdy(out_rdy), .out_data(out_data),
`ifdef MVU_ACC_SAT_EN
        .out_sat(out_sat),
`endif
        .sf_idx(sf_idx)
    );

    // SF=1 instance
    logic        a_in_v, a_in_rdy, a_out_v, a_out_rdy;
    logic [31:0] a_in_data;
    logic [47:0] a_out_data;
    logic [0:0]  a_sf_idx;
`ifdef MVU_ACC_SAT_EN
    logic        a_out_sat;
`endif

    mvu_pe_acc #(.PE(2), .TO(16), .TA(24), .SF(1)) u_sf1 (
        .clk(clk), .rst_n(rst_n), .in_v(a_in_v), .in_rdy(a_in_rdy), .in_data(a_in_data),
        .out_v(a_out_v), .out_rdy(a_out_rdy), .out_data(a_out_data),
`ifdef MVU_ACC_SAT_EN
        .out_sat(a_out_sat),
`endif
        .sf_idx(a_sf_idx)
    );

    // Overflow instance: PE=1, TO=16, TA=16, SF=2
    logic        b_in_v, b_in_rdy, b_out_v, b_out_rdy;
    logic [15:0] b_in_data;
    logic [15:0] b_out_data;
    logic [0:0]  b_sf_idx;
`ifdef MVU_ACC_SAT_EN
    logic        b_out_sat;
`endif

    mvu_pe_acc #(.PE(1), .TO(16), .TA(16), .SF(2)) u_ovf (
        .clk(clk), .rst_n(rst_n), .in_v(b_in_v), .in_rdy(b_in_rdy), .in_data(b_in_data),
        .out_v(b_out_v), .out_rdy(b_out_rdy), .out_data(b_out_data),
`ifdef MVU_ACC_SAT_EN
        .out_sat(b_out_sat),
`endif
        .sf_idx(b_sf_idx)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_v = 1'b0; in_data = '0; out_rdy = 1'b1;
        a_in_v = 1'b0; a_in_data = '0; a_out_rdy = 1'b1;
        b_in_v = 1'b0; b_in_data = '0; b_out_rdy = 1'b1;
        gap(2);
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_out_v",    64'(out_v), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_rdy",   64'(in_rdy), 64'd1);
        check("rst_sf_idx",   64'(sf_idx), 64'd0);

        // Basic fold: lane0 1..4, lane1 -5 x4
        for (int k = 1; k <= 4; k++) begin
            in_v = 1'b1; in_data = {16'hFFFB, 16'(k)};
            step();
            if (k == 3) check("basic_no_early_v", 64'(out_v), 64'd0);
        end
        check("basic_out_v",    64'(out_v), 64'd1);
        check("basic_out_data", 64'(out_data), 64'hFFFFEC_00000A);
        check("basic_sf_wrap",  64'(sf_idx), 64'd0);

        // Second fold of zeros; first beat takes the pending result
        in_data = 32'h0;
        step();
        check("zero_take_v",    64'(out_v), 64'd0);
        check("zero_hold_data", 64'(out_data), 64'hFFFFEC_00000A);
        gap(3);
        check("zero_out_v",    64'(out_v), 64'd1);
        check("zero_out_data", 64'(out_data), 64'h0);
        in_v = 1'b0;
        step();
        check("zero_drop_v", 64'(out_v), 64'd0);

        // Gapped input, 3 idle cycles between beats
        for (int k = 1; k <= 4; k++) begin
            in_v = 1'b1; in_data = {16'hFFFB, 16'(k)};
            step();
            in_v = 1'b0;
            if (k < 4) begin
                check($sformatf("gap_sf_idx_%0d", k), 64'(sf_idx), 64'(k));
                gap(3);
                check($sformatf("gap_no_v_%0d", k), 64'(out_v), 64'd0);
                check($sformatf("gap_idx_hold_%0d", k), 64'(sf_idx), 64'(k));
            end else begin
                check("gap_out_v",    64'(out_v), 64'd1);
                check("gap_out_data", 64'(out_data), 64'hFFFFEC_00000A);
                check("gap_sf_idx_4", 64'(sf_idx), 64'd0);
                gap(3);
            end
        end

        // Backpressure: first result held while the next fold waits
        for (int k = 1; k <= 4; k++) begin
            in_v = 1'b1; in_data = {16'hFFFB, 16'(k)};
            step();
        end
        out_rdy = 1'b0;
        in_data = {16'd2, 16'd1};
        #1;
        check("bp_in_rdy_low", 64'(in_rdy), 64'd0);
        gap(3);
        check("bp_out_v",     64'(out_v), 64'd1);
        check("bp_data_hold", 64'(out_data), 64'hFFFFEC_00000A);
        check("bp_no_accept", 64'(sf_idx), 64'd0);
        out_rdy = 1'b1;
        step();
        check("bp_release_v",  64'(out_v), 64'd0);
        check("bp_first_beat", 64'(sf_idx), 64'd1);
        gap(3);
        check("bp_second_v",    64'(out_v), 64'd1);
        check("bp_second_data", 64'(out_data), 64'h000008_000004);

        // Reset mid-fold after two beats (acc lane0 = 3)
        in_data = {16'd0, 16'd1};
        step();
        in_data = {16'd0, 16'd2};
        step();
        check("mid_sf_idx", 64'(sf_idx), 64'd2);
        in_v = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_out_v",    64'(out_v), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_sf_idx",   64'(sf_idx), 64'd0);
        for (int k = 0; k < 4; k++) begin
            in_v = 1'b1; in_data = {16'd1, 16'd1};
            step();
        end
        in_v = 1'b0;
        check("mid_out_v",    64'(out_v), 64'd1);
        check("mid_out_data", 64'(out_data), 64'h000004_000004);

        // SF=1: take and new final in the same cycle, no bubble
        a_in_v = 1'b1; a_in_data = {16'hFFF9, 16'd7};
        step();
        check("sf1_v_7",    64'(a_out_v), 64'd1);
        check("sf1_data_7", 64'(a_out_data), 64'hFFFFF9_000007);
        a_in_data = {16'hFFF8, 16'd8};
        step();
        check("sf1_v_8",    64'(a_out_v), 64'd1);
        check("sf1_data_8", 64'(a_out_data), 64'hFFFFF8_000008);
        a_in_data = {16'hFFF7, 16'd9};
        step();
        check("sf1_v_9",    64'(a_out_v), 64'd1);
        check("sf1_data_9", 64'(a_out_data), 64'hFFFFF7_000009);
        check("sf1_in_rdy", 64'(a_in_rdy), 64'd1);
        a_in_v = 1'b0;
        step();
        check("sf1_drop_v", 64'(a_out_v), 64'd0);

        // Overflow: 0x7FFF + 0x0001 with TA=16
        b_in_v = 1'b1; b_in_data = 16'h7FFF;
        step();
        b_in_data = 16'h0001;
        step();
        check("ovf_out_v", 64'(b_out_v), 64'd1);
`ifdef MVU_ACC_SAT_EN
        check("ovf_out_data", 64'(b_out_data), 64'h7FFF);
        check("ovf_out_sat",  64'(b_out_sat), 64'd1);
`else
        check("ovf_out_data", 64'(b_out_data), 64'h8000);
`endif
        step();
        step();
        check("ovf_next_data", 64'(b_out_data), 64'h0002);
`ifdef MVU_ACC_SAT_EN
        check("ovf_next_sat", 64'(b_out_sat), 64'd0);
`endif
        b_in_v = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvu_pe_acc.md
Name: mvu_pe_acc

Overview:
- Sits directly downstream of the PE array in the matrix-vector unit.
- Each PE emits one signed partial dot product (SIMD products summed) per synapse-fold beat. This block accumulates SF consecutive beats per PE lane into a full neuron result.
- Presents results to the output stage through a valid/ready register slice.
- Backpressure propagates upstream via in_rdy.

Parameters:
- PE, 2, number of parallel PE lanes, all sharing one control path.
- TO, 16, width of each signed PE partial sum at the input.
- TA, 24, width of each signed accumulator and output lane; TA >= TO.
- SF, 4, synapse fold: number of input beats per output result; SF >= 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_v  input  1  input beat valid.
- in_rdy  output  1  block can accept a beat this cycle.
- in_data  input  PE*TO  packed partial sums; lane p at [p*TO +: TO], two's complement.
- out_v  output  1  output result valid.
- out_rdy  input  1  downstream accepts result.
- out_data  output  PE*TA  packed results; lane p at [p*TA +: TA].
- sf_idx  output  $clog2(SF) (min 1)  index of the next beat to be accepted, for debug/upstream alignment.

Behaviour:
- Reset (rst_n=0 at clk edge): out_v=0, out_data=0, accumulators=0, sf_cnt=0. in_rdy is 1 in the cycle after reset.
- Reset mid-fold discards the partial accumulation and any pending output.
- Beat acceptance: a beat is accepted when in_v && in_rdy.
- in_rdy = !(out_v && !out_rdy). The block stalls completely while a result is held and not taken. It never accepts while the output register is blocked.
- Sign extension: each lane input is sign-extended from TO to TA bits.
- Accepted beat with sf_cnt==0: acc[p] <= sext(in[p]). Any prior value is discarded; no clear cycle is needed.
- Accepted beat with 0<sf_cnt<SF-1: acc[p] <= acc[p] + sext(in[p]).
- Accepted beat with sf_cnt==SF-1 (final beat): out_data[p] <= acc[p] + sext(in[p]), or sext(in[p]) when SF==1. Also out_v <= 1 and sf_cnt <= 0.
- Latency: the result appears on out_data/out_v the cycle after the final beat is accepted.
- Counter: sf_cnt increments by 1 per accepted beat and wraps SF-1 -> 0. It is unchanged on cycles with no accepted beat, so gaps in in_v are allowed anywhere in a fold. sf_idx = sf_cnt.
- Output handshake:
  - out_v && out_rdy with no new final beat: out_v <= 0, and out_data holds its last value.
  - Final beat accepted in the same cycle as out_v && out_rdy: out_data is replaced and out_v stays 1. This gives full throughput of one result per SF cycles with no bubble.
  - While out_v && !out_rdy: out_data and out_v are stable.
- Arithmetic: signed two's complement; overflow wraps modulo 2^TA unless the optional feature is enabled.
- States, implicit in (sf_cnt, out_v):
  - ACCUM: out_v=0.
  - ACCUM+HOLD: out_v=1 with out_rdy=1; accepting continues.
  - STALL: out_v=1, out_rdy=0, in_rdy=0.
- in_v is ignored when in_rdy=0; upstream must hold its data.

Optional Feature:
- MVU_ACC_SAT_EN defined: every add, including the final add, saturates to [-2^(TA-1), 2^(TA-1)-1] per lane. A per-lane sticky saturation flag is ORed across the fold. A 1-bit output port out_sat is added, asserted with out_v when any lane saturated in that fold, and cleared on the first beat of the next fold.
- MVU_ACC_SAT_EN undefined: wrap-around arithmetic and no out_sat port.

Test Plan:
- Basic fold: PE=2, TO=16, TA=24, SF=4, out_rdy=1. Lane0 inputs 1,2,3,4 and lane1 inputs -5,-5,-5,-5 on back-to-back beats -> out_v pulses 1 cycle after beat 4 with lane0=10, lane1=-20 (0xFFFFEC). Then a second fold of zeros -> 0,0.
- Gapped input: same values with in_v deasserted 3 cycles between beats -> same result. sf_idx sequence is 0,1,2,3,0. No spurious out_v.
- Backpressure: out_rdy=0 when the first result appears, with the next fold streaming -> in_rdy=0, out_data stable at 10/-20 until out_rdy=1. No beat is lost and the second result is correct.
- Simultaneous take and new final: SF=1, in_v=1 and out_rdy=1 every cycle with inputs 7,8,9 -> out_v stays 1 and out_data follows 7,8,9 on consecutive cycles.
- Reset mid-fold: after 2 beats (acc=3), pulse rst_n=0 for 1 cycle, then feed 4 beats of 1 -> result 4, not 7. out_v=0 and out_data=0 immediately after reset.
- Overflow: TA=16, TO=16, SF=2, inputs 0x7FFF,0x0001 -> result 0x8000 without the macro; 0x7FFF with out_sat=1 under MVU_ACC_SAT_EN.
